fp32_inv_rr_arbiter: RTL and testbench
======================================

FP32_INV_RR_ARBITER -- requirements
Module: fp32_inv_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, max cycles waited for the reciprocal unit result.
REQ-003 SHALL have localparam IDW = $clog2(N_REQ), the requester index width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-007 SHALL have port req_data  input  N_REQ*32  per-requester FP32 operand; slice i is [32*i+31:32*i].
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester accept; at most one bit high.
REQ-009 SHALL have port rsp_valid  output  1  result valid, held until accepted.
REQ-010 SHALL have port rsp_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port rsp_id  output  IDW  index of the requester owning the result.
REQ-012 SHALL have port rsp_data  output  32  FP32 reciprocal result.
REQ-013 SHALL have port rsp_err  output  1  result produced by timeout, not by the unit.
REQ-014 SHALL have port u_in_valid  output  1  one-cycle start pulse to the reciprocal unit.
REQ-015 SHALL have port u_in_fp32  output  32  operand to the reciprocal unit.
REQ-016 SHALL have port u_out_valid  input  1  reciprocal unit result pulse.
REQ-017 SHALL have port u_out_fp32  input  32  reciprocal unit result.
REQ-018 SHALL have port busy  output  1  high in every state except S_IDLE.

Function
REQ-019 SHALL implement the FSM S_IDLE -> S_ISSUE -> S_WAIT -> S_RESP -> S_IDLE, with one request in flight at a time.
REQ-020 In S_IDLE, SHALL drive req_ready[g] combinationally high for the winner g: the first set req_valid bit at or after rr_ptr, searching upward with wrap.
REQ-021 When req_valid[g] and req_ready[g] are both high, SHALL latch req_data slice g into op_q and g into id_q, then enter S_ISSUE.
REQ-022 In S_ISSUE, SHALL assert u_in_valid for exactly one cycle with u_in_fp32 = op_q, clear the timeout counter, then enter S_WAIT.
REQ-023 In S_WAIT, on u_out_valid, SHALL latch u_out_fp32 into rsp_data, clear rsp_err, and enter S_RESP.
REQ-024 In S_RESP, SHALL hold rsp_valid high with rsp_id = id_q; when rsp_ready is high, SHALL set rr_ptr = (id_q+1) mod N_REQ and enter S_IDLE.
REQ-025 Accept-to-issue latency SHALL be 1 cycle; unit-result-to-rsp_valid latency SHALL be 1 cycle.
REQ-026 Outside S_WAIT, u_out_valid SHALL be ignored.
REQ-027 Within S_RESP, u_out_valid SHALL not modify rsp_data.
REQ-028 Requests that are not granted SHALL see req_ready low and are not consumed; requesters hold req_valid and req_data.
REQ-029 When req_valid is withdrawn in the same cycle as the grant, no transfer SHALL occur and the FSM SHALL stay in S_IDLE.
REQ-030 rsp_valid, rsp_data, rsp_id and rsp_err SHALL be stable while rsp_valid is high and rsp_ready is low.
REQ-031 u_in_valid and rsp_valid SHALL be registered outputs.

Reset
REQ-032 When rst is asserted, the FSM SHALL go to S_IDLE asynchronously.
REQ-033 When rst is asserted, the following SHALL be set to zero: rr_ptr, id_q, op_q, rsp_data, rsp_id, rsp_err, rsp_valid, u_in_valid, busy, timeout counter, discard flag.
REQ-034 A reset during S_WAIT or S_RESP SHALL drop the transaction with no response.
REQ-035 The reciprocal unit SHALL share the same rst.

Configuration
REQ-036 With INV_ARB_TIMEOUT_EN defined, when the S_WAIT counter reaches TIMEOUT_CYC, SHALL load rsp_data = 32'h7FC00000, set rsp_err = 1, set the discard flag, and enter S_RESP.
REQ-037 While the discard flag is set, the first u_out_valid seen in any state SHALL be dropped and SHALL clear the flag.
REQ-038 Without INV_ARB_TIMEOUT_EN, there SHALL be no counter and no discard flag, S_WAIT SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Structure
REQ-039 Package fp32_inv_arb_pkg SHALL hold the state enum inv_arb_st_t and FP32_QNAN = 32'h7FC00000.
REQ-040 The round-robin winner search SHALL be a sub-module fp32_rr_pick (inputs: req vector, ptr; outputs: any, idx).

Verification
REQ-041 The bench SHALL use a stub unit with 8-cycle fixed latency returning the exact reciprocal.
REQ-042 Single request: req_valid = 4'b0001, req_data0 = 32'h40000000 -> u_in_valid 1 cycle after accept; rsp_valid 9 cycles after issue with rsp_id = 0, rsp_data = 32'h3F000000, rsp_err = 0.
REQ-043 Fairness: all four requesters valid and held for 8 transactions -> rsp_id sequence 0,1,2,3,0,1,2,3.
REQ-044 Backpressure: rsp_ready low for 5 cycles -> rsp outputs stable; no new req_ready and no u_in_valid until the handshake; rr_ptr then advances.
REQ-045 Mid-operation reset: assert rst in S_WAIT -> busy = 0 and rsp_valid = 0 immediately, and no response follows.
REQ-046 Timeout (INV_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, stub never answers) -> rsp_data = 32'h7FC00000, rsp_err = 1; a late u_out_valid is discarded and the next request returns its correct result.

Source files
------------

// File: rtl/fp32_inv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp32_inv_arb_pkg
// Purpose : Shared types and constants for the FP32 reciprocal round-robin
//           arbiter (state encoding, canonical quiet NaN).
// Ports   : none (package)
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
package fp32_inv_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } inv_arb_st_t;

  // Result returned when the reciprocal unit does not answer in time.
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage
`default_nettype wire

// File: rtl/fp32_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : fp32_rr_pick
// Purpose : Round-robin winner search. Returns the first set bit of req at or
//           above ptr, wrapping to the lowest set bit when none is found there.
// Ports   : req [N_REQ]  - request vector
//           ptr [IDW]    - search start index (always < N_REQ)
//           any          - at least one request is set
//           idx [IDW]    - winning index (valid when any is high)
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
module fp32_rr_pick
  import fp32_inv_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  logic           hi_any;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Scan downward so the lowest qualifying index is the last one written:
  // hi_* tracks the lowest set bit at/above ptr, lo_* the lowest set bit
  // overall (the wrap-around candidate).
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int c = N_REQ - 1; c >= 0; c--) begin
      if (req[c]) begin
        lo_idx = IDW'(c);
        if (c >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = IDW'(c);
        end
      end
    end
  end

  assign any = |req;
  assign idx = hi_any ? hi_idx : lo_idx;

endmodule
`default_nettype wire

// File: rtl/fp32_inv_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fp32_inv_rr_arbiter
// Purpose : Shares one FP32 reciprocal unit among N_REQ requesters using
//           round-robin arbitration, one operation in flight at a time.
// Ports   : clk, rst              - clock, asynchronous active-high reset
//           req_valid/req_ready   - per-requester handshake
//           req_data              - per-requester operand, slice i=[32i+31:32i]
//           rsp_valid/rsp_ready   - result handshake (held until accepted)
//           rsp_id/rsp_data/rsp_err - result owner, value, timeout flag
//           u_in_valid/u_in_fp32  - start pulse and operand to the unit
//           u_out_valid/u_out_fp32- result pulse and value from the unit
//           busy                  - high whenever the FSM is not idle
// Macros  : INV_ARB_TIMEOUT_EN - enables the S_WAIT timeout (TIMEOUT_CYC),
//           returning a quiet NaN with rsp_err set and discarding the late
//           unit answer. Without it S_WAIT waits forever and rsp_err is 0.
// Revision: 1.0 - initial release
// ============================================================================
module fp32_inv_rr_arbiter
  import fp32_inv_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 1023,
  localparam int IDW         = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*32-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                u_in_valid,
  output logic [31:0]         u_in_fp32,
  input  logic                u_out_valid,
  input  logic [31:0]         u_out_fp32,
  output logic                busy
);

  inv_arb_st_t    state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [31:0]    op_q;
  logic           win_any;
  logic [IDW-1:0] win;
  logic [31:0]    sel_data;
  logic [IDW-1:0] next_ptr;

`ifdef INV_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]  to_cnt;
  logic           discard;
`else
  assign rsp_err = 1'b0;
`endif

  fp32_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (win_any),
    .idx (win)
  );

  // Grant is combinational in S_IDLE so a requester that drops valid before
  // the edge simply loses the slot without a transfer.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state == S_IDLE) && win_any && (win == IDW'(gi));
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  assign next_ptr  = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
  assign u_in_fp32 = op_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      op_q       <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      u_in_valid <= 1'b0;
`ifdef INV_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      to_cnt     <= '0;
      discard    <= 1'b0;
`endif
    end else begin
      u_in_valid <= 1'b0;

`ifdef INV_ARB_TIMEOUT_EN
      // The stale answer of a timed-out operation is consumed here in any
      // state; a timeout in the same cycle re-arms the flag below.
      if (discard && u_out_valid) begin
        discard <= 1'b0;
      end
`endif

      case (state)
        S_IDLE: begin
          if (win_any) begin
            op_q       <= sel_data;
            id_q       <= win;
            u_in_valid <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
`ifdef INV_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state  <= S_WAIT;
        end

        S_WAIT: begin
`ifdef INV_ARB_TIMEOUT_EN
          if (u_out_valid && !discard) begin
            rsp_data  <= u_out_fp32;
            rsp_err   <= 1'b0;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (to_cnt == CW'(TIMEOUT_CYC)) begin
            rsp_data  <= FP32_QNAN;
            rsp_err   <= 1'b1;
            discard   <= 1'b1;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
`else
          if (u_out_valid) begin
            rsp_data  <= u_out_fp32;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_inv_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp32_inv_rr_arbiter
// Purpose : Self-checking bench for fp32_inv_rr_arbiter with an 8-cycle
//           reciprocal stub (exact for power-of-two operands) and a response
//           scoreboard. Timeout checks run when INV_ARB_TIMEOUT_EN is defined.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp32_inv_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            u_in_valid;
  logic [31:0]     u_in_fp32;
  logic            u_out_valid;
  logic [31:0]     u_out_fp32;
  logic            busy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb [$];
  exp_t mon_e;

  logic [31:0] opnd [N];
  logic [31:0] rcp  [N];

  always #5 clk = ~clk;

  fp32_inv_rr_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .u_in_valid  (u_in_valid),
    .u_in_fp32   (u_in_fp32),
    .u_out_valid (u_out_valid),
    .u_out_fp32  (u_out_fp32),
    .busy        (busy)
  );

  // ---------------- reciprocal unit stub (8-cycle latency) ----------------
  logic        stub_en = 1'b1;
  logic [3:0]  stub_cnt;
  logic [31:0] stub_res;
  logic [31:0] stub_out;
  logic        stub_valid;
  logic        man_valid = 1'b0;
  logic [31:0] man_data  = 32'h0;

  function automatic logic [31:0] recip_pow2(input logic [31:0] x);
    logic [7:0] e;
    e = 8'd254 - x[30:23];
    return {x[31], e, 23'd0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt   <= 4'd0;
      stub_res   <= 32'h0;
      stub_out   <= 32'h0;
      stub_valid <= 1'b0;
    end else begin
      stub_valid <= 1'b0;
      if (stub_cnt != 4'd0) begin
        stub_cnt <= stub_cnt - 4'd1;
        if (stub_cnt == 4'd1 && stub_en) begin
          stub_valid <= 1'b1;
          stub_out   <= stub_res;
        end
      end
      if (u_in_valid) begin
        stub_cnt <= 4'd7;
        stub_res <= recip_pow2(u_in_fp32);
      end
    end
  end

  assign u_out_valid = stub_valid | man_valid;
  assign u_out_fp32  = man_valid ? man_data : stub_out;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g, input int max_cyc);
    int k;
    g = -1;
    k = 0;
    while (g < 0 && k < max_cyc) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && g < 0) g = i;
      end
      if (g < 0) begin
        step();
        k++;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic grant_one(input logic [N-1:0] vmask, input int exp_g, input string tag);
    int g;
    sb.push_back('{id: IDW'(exp_g), data: rcp[exp_g], err: 1'b0});
    req_valid = vmask;
    #1;
    wait_grant(g, 5);
    chk(tag, 32'(g), 32'(exp_g));
    step();
    req_valid = '0;
    wait_idle();
  endtask

  // ---------------- response monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id",   32'(rsp_id),  32'(mon_e.id));
        chk("rsp_data", rsp_data,     mon_e.data);
        chk("rsp_err",  32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int g;
    logic seen;

    opnd[0] = 32'h4000_0000;  rcp[0] = 32'h3F00_0000;   //  2.0  ->  0.5
    opnd[1] = 32'h4080_0000;  rcp[1] = 32'h3E80_0000;   //  4.0  ->  0.25
    opnd[2] = 32'hC100_0000;  rcp[2] = 32'hBE00_0000;   // -8.0  -> -0.125
    opnd[3] = 32'h3F00_0000;  rcp[3] = 32'h4000_0000;   //  0.5  ->  2.0

    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = opnd[i];

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("rst_u_in",      32'(u_in_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,        32'd0);
    chk("rst_rsp_id",    32'(rsp_id),     32'd0);
    chk("rst_rsp_err",   32'(rsp_err),    32'd0);
    rst = 1'b0;
    step();

    // Single request from requester 0: issue 1 cycle after accept,
    // rsp_valid 9 cycles after issue.
    sb.push_back('{id: 2'd0, data: 32'h3F00_0000, err: 1'b0});
    req_valid = 4'b0001;
    #1;
    chk("s1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("s1_issue", 32'(u_in_valid), 32'd1);
    chk("s1_op",    u_in_fp32,       32'h4000_0000);
    chk("s1_busy",  32'(busy),       32'd1);
    n = 0;
    step();
    n = 1;
    chk("s1_pulse_width", 32'(u_in_valid), 32'd0);
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("s1_latency", 32'(n), 32'd9);
    wait_idle();

    // Round-robin pointer: after id 0 -> start at 1; after 2 -> 3 wraps to 0.
    grant_one(4'b0101, 2, "rr_skip_to_2");
    grant_one(4'b0011, 0, "rr_wrap_to_0");
    grant_one(4'b1000, 3, "rr_only_3");

    // Fairness: all requesters held valid for 8 transactions.
    for (int t = 0; t < 8; t++) sb.push_back('{id: IDW'(t % 4), data: rcp[t % 4], err: 1'b0});
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 8; t++) begin
      wait_grant(g, 40);
      chk("fair_grant", 32'(g), 32'(t % 4));
      step();
    end
    req_valid = '0;
    wait_idle();

    // Valid withdrawn before the edge: no transfer.
    req_valid = 4'b0010;
    #1;
    chk("wd_ready", 32'(req_ready), 32'h2);
    #2;
    req_valid = '0;
    step();
    chk("wd_busy", 32'(busy),       32'd0);
    chk("wd_u_in", 32'(u_in_valid), 32'd0);

    // Backpressure: response held stable, no new grant or issue.
    rsp_ready = 1'b0;
    sb.push_back('{id: 2'd1, data: rcp[1], err: 1'b0});
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    req_valid = 4'b0101;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid),  32'd1);
      chk("bp_data",  rsp_data,        rcp[1]);
      chk("bp_id",    32'(rsp_id),     32'd1);
      chk("bp_err",   32'(rsp_err),    32'd0);
      chk("bp_ready", 32'(req_ready),  32'd0);
      chk("bp_u_in",  32'(u_in_valid), 32'd0);
      step();
    end
    sb.push_back('{id: 2'd2, data: rcp[2], err: 1'b0});
    sb.push_back('{id: 2'd0, data: rcp[0], err: 1'b0});
    rsp_ready = 1'b1;
    #1;
    wait_grant(g, 5);
    chk("bp_next_grant", 32'(g), 32'd2);
    step();
    req_valid = 4'b0001;
    #1;
    wait_grant(g, 40);
    chk("bp_then_grant", 32'(g), 32'd0);
    step();
    req_valid = '0;
    wait_idle();

    // Reset while waiting on the unit: immediate idle, no response.
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (3) step();
    chk("mr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy",      32'(busy),      32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      step();
      if (rsp_valid || u_in_valid) seen = 1'b1;
    end
    chk("mr_no_rsp", 32'(seen), 32'd0);

`ifdef INV_ARB_TIMEOUT_EN
    // Timeout: unit silent; NaN with err after 16 counted wait cycles.
    stub_en = 1'b0;
    sb.push_back('{id: 2'd3, data: 32'h7FC0_0000, err: 1'b1});
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    chk("to_latency", 32'(n),       32'd18);
    chk("to_err",     32'(rsp_err), 32'd1);
    wait_idle();

    // Late answer arrives during the next request and must be dropped.
    stub_en = 1'b1;
    sb.push_back('{id: 2'd0, data: rcp[0], err: 1'b0});
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();
    man_data  = 32'h1234_5678;
    man_valid = 1'b1;
    step();
    man_valid = 1'b0;
    chk("to_late_ignored", 32'(rsp_valid), 32'd0);
    wait_idle();
`endif

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
